// File: rtl/pl_dmem_arbiter.sv
// pl_dmem_arbiter
// Shares the pipeline's single-ported data memory between the CPU MEM stage
// and a DMA/loader requester. The CPU normally wins. After STARVE_LIMIT
// consecutive denied DMA cycles the DMA is guaranteed the next slot.
// Whenever the CPU requests but is not granted, cpu_stall freezes the pipeline.
//
// Build option: define DMEM_ARB_STATS_EN to build the saturating statistics
// counters (stat_stall_cnt, stat_dma_cnt). Without it both ports read 0 and
// no counter flops exist.
module pl_dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,   // legal range 1..255
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,

    // CPU MEM stage port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,

    // DMA / loader port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic [31:0]       dma_rdata,
    output logic              dma_rvalid,

    // Data memory side
    output logic              mem_enable,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,

    // Statistics
    output logic [STAT_W-1:0] stat_stall_cnt,
    output logic [STAT_W-1:0] stat_dma_cnt
);

    typedef enum logic {
        CPU_PRIO  = 1'b0,
        DMA_FORCE = 1'b1
    } arb_state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    arb_state_t state_reg;
    arb_state_t state_next;
    logic [7:0] starve_cnt_reg;
    logic [7:0] starve_cnt_next;

    logic       cpu_gnt_c;
    logic       dma_gnt_c;
    logic       dma_rd_capture;
    logic [31:0] dma_rdata_reg;
    logic        dma_rvalid_reg;

    // State register and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= CPU_PRIO;
            starve_cnt_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Grant decision, starvation counter update and next-state logic
    always_comb begin
        cpu_gnt_c       = 1'b0;
        dma_gnt_c       = 1'b0;
        starve_cnt_next = 8'd0;
        state_next      = state_reg;

        // Grants are held off for the whole time reset is asserted.
        if (!reset) begin
            unique case (state_reg)
                CPU_PRIO: begin
                    if (cpu_req) begin
                        cpu_gnt_c = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt_c = 1'b1;
                    end
                end
                DMA_FORCE: begin
                    // A withdrawn DMA request hands the slot straight back
                    // to the CPU in the same cycle.
                    if (dma_req) begin
                        dma_gnt_c = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt_c = 1'b1;
                    end
                end
                default: begin
                    cpu_gnt_c = 1'b0;
                    dma_gnt_c = 1'b0;
                end
            endcase
        end

        // Count consecutive denied DMA cycles; any grant or idle cycle restarts.
        if (dma_req && !dma_gnt_c) begin
            if (starve_cnt_reg >= STARVE_MAX) begin
                starve_cnt_next = STARVE_MAX;
            end else begin
                starve_cnt_next = starve_cnt_reg + 8'd1;
            end
        end

        unique case (state_reg)
            CPU_PRIO: begin
                if (starve_cnt_next == STARVE_MAX) begin
                    state_next = DMA_FORCE;
                end
            end
            DMA_FORCE: begin
                // Either the DMA was granted or it dropped its request; in
                // both cases priority returns to the CPU.
                state_next = CPU_PRIO;
            end
            default: begin
                state_next = CPU_PRIO;
            end
        endcase
    end

    assign cpu_gnt   = cpu_gnt_c;
    assign dma_gnt   = dma_gnt_c;
    assign cpu_stall = cpu_req & ~cpu_gnt_c;

    // Steer the granted port onto the memory; everything is 0 when idle
    always_comb begin
        mem_enable     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        if (cpu_gnt_c) begin
            mem_enable     = 1'b1;
            mem_read       = ~cpu_we;
            mem_write      = cpu_we;
            mem_address    = cpu_addr;
            mem_write_data = cpu_wdata;
        end else if (dma_gnt_c) begin
            mem_enable     = 1'b1;
            mem_read       = ~dma_we;
            mem_write      = dma_we;
            mem_address    = dma_addr;
            mem_write_data = dma_wdata;
        end
    end

    // CPU load data is passed through combinationally in the grant cycle only
    assign cpu_rdata = (cpu_gnt_c && !cpu_we) ? mem_read_data : 32'd0;

    assign dma_rd_capture = dma_gnt_c & ~dma_we;

    // Register DMA read data; rvalid pulses the cycle after the read grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_rdata_reg  <= 32'd0;
            dma_rvalid_reg <= 1'b0;
        end else begin
            dma_rvalid_reg <= dma_rd_capture;
            if (dma_rd_capture) begin
                dma_rdata_reg <= mem_read_data;
            end
        end
    end

    assign dma_rdata  = dma_rdata_reg;
    assign dma_rvalid = dma_rvalid_reg;

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] stall_cnt_reg;
    logic [STAT_W-1:0] dma_cnt_reg;

    // Saturating counters: CPU stall cycles and DMA grants
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            dma_cnt_reg   <= '0;
        end else begin
            if (cpu_stall && (stall_cnt_reg != {STAT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + STAT_W'(1);
            end
            if (dma_gnt_c && (dma_cnt_reg != {STAT_W{1'b1}})) begin
                dma_cnt_reg <= dma_cnt_reg + STAT_W'(1);
            end
        end
    end

    assign stat_stall_cnt = stall_cnt_reg;
    assign stat_dma_cnt   = dma_cnt_reg;
`else
    assign stat_stall_cnt = '0;
    assign stat_dma_cnt   = '0;
`endif

endmodule

// File: tb/tb_pl_dmem_arbiter.sv
// Testbench for pl_dmem_arbiter. A behavioural memory sits behind the mem_*
// ports. The stimulus process pushes per-cycle expectations computed by a
// rule-level reference model. A monitor pops them on every falling edge and
// compares them with the DUT outputs. Directed scenarios also check a few
// literal required values.
module tb_pl_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_enable, mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [15:0] stat_stall_cnt, stat_dma_cnt;

    pl_dmem_arbiter #(.STARVE_LIMIT(LIMIT), .STAT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .stat_stall_cnt(stat_stall_cnt), .stat_dma_cnt(stat_dma_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-ported memory: combinational read, write at the edge
    logic [31:0] tb_mem [0:63];
    assign mem_read_data = tb_mem[mem_address[7:2]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_address[7:2]] <= mem_write_data;
    end

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        cpu_gnt;
        logic        dma_gnt;
        logic        cpu_stall;
        logic        mem_enable;
        logic        mem_read;
        logic        mem_write;
        logic        dma_rvalid;
        logic [31:0] cpu_rdata;
        logic [31:0] mem_address;
        logic [31:0] mem_write_data;
        logic [31:0] dma_rdata;
        logic [15:0] stall_cnt;
        logic [15:0] dma_cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] ref_mem [0:63];
    int          m_wait;        // consecutive cycles the DMA has been refused
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [15:0] m_stall_cnt;
    logic [15:0] m_dma_cnt;
    logic        last_dma_win;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge and queue the
    // response the arbitration rules require for that cycle.
    task automatic drive(input logic rst,
                         input logic creq, input logic cwe,
                         input logic [31:0] caddr, input logic [31:0] cwdata,
                         input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwdata);
        exp_t e;
        logic cw;
        logic dw;
        @(posedge clk);
        #1;
        reset     = rst;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwdata;
        dma_req   = dreq;
        dma_we    = dwe;
        dma_addr  = daddr;
        dma_wdata = dwdata;
        e = '0;
        if (rst) begin
            e.cpu_stall  = creq;
            m_wait       = 0;
            m_rvalid     = 1'b0;
            m_rdata      = 32'd0;
            m_stall_cnt  = 16'd0;
            m_dma_cnt    = 16'd0;
            last_dma_win = 1'b0;
        end else begin
            // DMA wins when the CPU is idle, or once it has waited LIMIT cycles.
            dw = dreq && (!creq || (m_wait >= LIMIT));
            cw = creq && !dw;
            e.cpu_gnt    = cw;
            e.dma_gnt    = dw;
            e.cpu_stall  = creq && !cw;
            e.mem_enable = cw || dw;
            if (cw) begin
                e.mem_read       = !cwe;
                e.mem_write      = cwe;
                e.mem_address    = caddr;
                e.mem_write_data = cwdata;
                if (!cwe) e.cpu_rdata = ref_mem[caddr[7:2]];
            end else if (dw) begin
                e.mem_read       = !dwe;
                e.mem_write      = dwe;
                e.mem_address    = daddr;
                e.mem_write_data = dwdata;
            end
            e.dma_rvalid = m_rvalid;
            e.dma_rdata  = m_rdata;
`ifdef DMEM_ARB_STATS_EN
            e.stall_cnt = m_stall_cnt;
            e.dma_cnt   = m_dma_cnt;
`endif
            if (cw && cwe) ref_mem[caddr[7:2]] = cwdata;
            if (dw && dwe) ref_mem[daddr[7:2]] = dwdata;
            m_rvalid = dw && !dwe;
            if (dw && !dwe) m_rdata = ref_mem[daddr[7:2]];
            if (dreq && !dw) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
            else             m_wait = 0;
            if (e.cpu_stall && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
            if (dw && m_dma_cnt != 16'hFFFF) m_dma_cnt = m_dma_cnt + 16'd1;
            last_dma_win = dw;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic rst);
        drive(rst, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Monitor: every cycle is a transaction; compare all outputs to the queue
    initial begin : monitor
        exp_t e;
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cpu_gnt",        32'(cpu_gnt),        32'(e.cpu_gnt));
                chk("dma_gnt",        32'(dma_gnt),        32'(e.dma_gnt));
                chk("cpu_stall",      32'(cpu_stall),      32'(e.cpu_stall));
                chk("mem_enable",     32'(mem_enable),     32'(e.mem_enable));
                chk("mem_read",       32'(mem_read),       32'(e.mem_read));
                chk("mem_write",      32'(mem_write),      32'(e.mem_write));
                chk("mem_address",    mem_address,         e.mem_address);
                chk("mem_write_data", mem_write_data,      e.mem_write_data);
                chk("cpu_rdata",      cpu_rdata,           e.cpu_rdata);
                chk("dma_rvalid",     32'(dma_rvalid),     32'(e.dma_rvalid));
                chk("dma_rdata",      dma_rdata,           e.dma_rdata);
                chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'(e.stall_cnt));
                chk("stat_dma_cnt",   32'(stat_dma_cnt),   32'(e.dma_cnt));
                $display("txn %0d: rst=%b cpu_gnt=%b dma_gnt=%b stall=%b addr=%h rvalid=%b",
                         n, reset, cpu_gnt, dma_gnt, cpu_stall, mem_address, dma_rvalid);
                n++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic        hold;
        logic        rr, cq, cwe_r, dq, dwe_r;
        logic [31:0] da, dd;
        logic [15:0] exp_stat;

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
        m_wait = 0; m_rvalid = 1'b0; m_rdata = 32'd0;
        m_stall_cnt = 16'd0; m_dma_cnt = 16'd0; last_dma_win = 1'b0;

        // Reset with a CPU request: no grant, stall follows cpu_req
        idle(1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
        @(negedge clk);
        chk("reset_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("reset_cpu_gnt",   32'(cpu_gnt),   32'd0);
        idle(1'b0);

        // Fill memory with known contents through the CPU port
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'(i * 4), 32'hA5A5_0000 | 32'(i),
                  1'b0, 1'b0, 32'd0, 32'd0);
        end

        // CPU-only: store then load 0x10
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("cpu_only_store_gnt", 32'(cpu_gnt), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("cpu_only_load_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("cpu_only_load_stall", 32'(cpu_stall), 32'd0);

        // DMA-only: write then read 0x40, rvalid one cycle later
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h40, 32'h12345678);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        @(negedge clk);
        chk("dma_only_rvalid_early", 32'(dma_rvalid), 32'd0);
        idle(1'b0);
        @(negedge clk);
        chk("dma_only_rvalid", 32'(dma_rvalid), 32'd1);
        chk("dma_only_rdata",  dma_rdata, 32'h12345678);
        idle(1'b0);

        // Starvation: both ports requesting continuously for 10 cycles
        idle(1'b1);
        for (int c = 1; c <= 10; c++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h80, 32'd0);
            @(negedge clk);
            chk($sformatf("starve_dma_gnt_c%0d", c), 32'(dma_gnt), 32'((c == 5) || (c == 10)));
            chk($sformatf("starve_stall_c%0d", c),   32'(cpu_stall), 32'((c == 5) || (c == 10)));
        end
        idle(1'b0);
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        exp_stat = 16'd2;
`else
        exp_stat = 16'd0;
`endif
        chk("stats_stall", 32'(stat_stall_cnt), 32'(exp_stat));
        chk("stats_dma",   32'(stat_dma_cnt),   32'(exp_stat));

        // DMA withdraw in the forced cycle
        idle(1'b1);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'h40, 32'd0);
        @(negedge clk);
        chk("withdraw_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("withdraw_dma_gnt", 32'(dma_gnt), 32'd0);
        // Counter restarted from 0: DMA denied four more cycles, then forced
        for (int c = 1; c <= 5; c++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
            @(negedge clk);
            chk($sformatf("withdraw_restart_c%0d", c), 32'(dma_gnt), 32'(c == 5));
        end
        idle(1'b0);

        // Reset asserted in a DMA read grant cycle, CPU store also pending
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 32'h44, 32'h0BADF00D, 1'b1, 1'b0, 32'h40, 32'd0);
        @(negedge clk);
        chk("rst_mid_dma_gnt",   32'(dma_gnt),   32'd0);
        chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mid_stall",     32'(cpu_stall), 32'd1);
        idle(1'b0);
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_mid_rdata",  dma_rdata, 32'd0);

        // Randomized traffic; DMA holds its request stable until granted
        hold = 1'b0;
        dq = 1'b0; dwe_r = 1'b0; da = 32'd0; dd = 32'd0;
        for (int i = 0; i < 600; i++) begin
            rr    = ($urandom_range(0, 99) == 0);
            cq    = ($urandom_range(0, 99) < 70);
            cwe_r = 1'($urandom_range(0, 1));
            if (!hold) begin
                dq    = 1'($urandom_range(0, 1));
                dwe_r = 1'($urandom_range(0, 1));
                da    = $urandom & 32'hFFFF_FFFC;
                dd    = $urandom;
            end
            drive(rr, cq, cwe_r, $urandom & 32'hFFFF_FFFC, $urandom, dq, dwe_r, da, dd);
            hold = dq && !last_dma_win;
        end
        idle(1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
